stall_ctrl: RTL

Central stall/hazard controller for the 5-stage RISC-V pipeline. It is the producer of the `stall[5:0]` vector consumed by the pc_reg/if_id/id_ex/ex_mem/mem_wb pipeline registers, and the consumer of the `isload`/`loadrd` load-use indication and the `prediction_res` outcome those registers emit. It arbitrates IF, load-use and MEM stall requests, and tracks memory-wait duration with a watchdog.

---
 rtl/stall_ctrl_if.sv | 27 ++
 rtl/stall_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/stall_ctrl_if.sv
// rtl/stall_ctrl_if.sv - stall request / hazard / stall vector bundle between pipeline and stall_ctrl
interface stall_ctrl_if;
  logic       if_stall_req;
  logic       mem_stall_req;
  logic       ex_isload;
  logic [4:0] ex_loadrd;
  logic       id_reg1_read;
  logic       id_reg2_read;
  logic [4:0] id_reg1_addr;
  logic [4:0] id_reg2_addr;
  logic       prediction_res;
  logic [5:0] stall;
  logic       load_use;
  logic       mem_timeout;

  modport master (
    output if_stall_req, mem_stall_req, ex_isload, ex_loadrd,
           id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr, prediction_res,
    input  stall, load_use, mem_timeout
  );

  modport slave (
    input  if_stall_req, mem_stall_req, ex_isload, ex_loadrd,
           id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr, prediction_res,
    output stall, load_use, mem_timeout
  );
endinterface

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall arbiter with MEM-wait watchdog
// Optional STALL_PERF_EN adds saturating perf counters for load-use, MEM and IF stall rows.
module stall_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  stall_ctrl_if.slave  bus
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]  perf_lu,
  output logic [31:0]  perf_mem,
  output logic [31:0]  perf_if
`endif
);

  localparam logic [15:0] TO = TIMEOUT[15:0];

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic       hazard;
  logic [5:0] stall_w;
  logic       win_mem, win_lu, win_if;

  assign hazard = bus.ex_isload && (bus.ex_loadrd != 5'd0) &&
                  ((bus.id_reg1_read && (bus.id_reg1_addr == bus.ex_loadrd)) ||
                   (bus.id_reg2_read && (bus.id_reg2_addr == bus.ex_loadrd)));

  // Only the winning row drives stall, load_use and the perf counters.
  always_comb begin
    stall_w = 6'b000000;
    win_mem = 1'b0;
    win_lu  = 1'b0;
    win_if  = 1'b0;
    if (!rst) begin
      stall_w = 6'b000000;
    end else if (bus.mem_stall_req) begin
      stall_w = 6'b011111;
      win_mem = 1'b1;
    end else if (!bus.prediction_res) begin
      stall_w = 6'b000000;
    end else if (hazard) begin
      stall_w = 6'b000111;
      win_lu  = 1'b1;
    end else if (bus.if_stall_req) begin
      stall_w = 6'b000011;
      win_if  = 1'b1;
    end
  end

  assign bus.stall       = stall_w;
  assign bus.load_use    = win_lu;
  assign bus.mem_timeout = mem_timeout_q;

  always_comb begin
    state_d       = state_q;
    wd_cnt_d      = wd_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (rdy) begin
      case (state_q)
        RUN:     if (bus.mem_stall_req)  state_d = MEMWAIT;
        MEMWAIT: if (!bus.mem_stall_req) state_d = RUN;
        default: state_d = RUN;
      endcase
      // The edge entering MEMWAIT counts, so the TIMEOUT-th stalled edge reaches TO.
      if (bus.mem_stall_req) begin
        if (wd_cnt_q != TO) wd_cnt_d = wd_cnt_q + 16'd1;
      end else begin
        wd_cnt_d = 16'd0;
      end
      if (wd_cnt_d == TO) mem_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      wd_cnt_q      <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_cnt_q      <= wd_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_mem_q, perf_mem_d;
  logic [31:0] perf_if_q, perf_if_d;

  always_comb begin
    perf_lu_d  = perf_lu_q;
    perf_mem_d = perf_mem_q;
    perf_if_d  = perf_if_q;
    if (rdy) begin
      if (win_lu  && (perf_lu_q  != 32'hFFFF_FFFF)) perf_lu_d  = perf_lu_q  + 32'd1;
      if (win_mem && (perf_mem_q != 32'hFFFF_FFFF)) perf_mem_d = perf_mem_q + 32'd1;
      if (win_if  && (perf_if_q  != 32'hFFFF_FFFF)) perf_if_d  = perf_if_q  + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_lu_q  <= 32'd0;
      perf_mem_q <= 32'd0;
      perf_if_q  <= 32'd0;
    end else begin
      perf_lu_q  <= perf_lu_d;
      perf_mem_q <= perf_mem_d;
      perf_if_q  <= perf_if_d;
    end
  end

  assign perf_lu  = perf_lu_q;
  assign perf_mem = perf_mem_q;
  assign perf_if  = perf_if_q;
`endif

endmodule
